// File: rtl/imgproc_pkg.sv
// Shared image-processing definitions: line-buffer geometry, fill width and
// the line-buffer controller state encoding.
package imgproc_pkg;

    localparam int unsigned LINE_W_DEFAULT = 512;
    localparam int unsigned NUM_BUFS       = 4;
    localparam int unsigned LBC_FILL_W     = $clog2(NUM_BUFS * LINE_W_DEFAULT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } lbc_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable; wrap_c flags the enabled cycle that
// returns the count to zero.
module mod_counter #(
    parameter  int unsigned MOD   = 4,
    localparam int unsigned CNT_W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap_c
);

    assign wrap_c = en && (count == CNT_W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Line-buffer controller for a 3x3 window over four rotating line buffers.
// Define LBC_OVF_GUARD_EN to drop writes into a full buffer set and flag ovf_err.
module line_buf_ctrl #(
    parameter int unsigned LINE_W   = imgproc_pkg::LINE_W_DEFAULT,
    parameter int unsigned NUM_BUFS = imgproc_pkg::NUM_BUFS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic [NUM_BUFS-1:0]         buf_wr_en,
    output logic [NUM_BUFS-1:0]         buf_rd_en,
    output logic [$clog2(NUM_BUFS)-1:0] rd_top_sel,
    output logic                        kernel_valid,
    output logic                        interrupt,
    output logic                        ovf_err
);

    import imgproc_pkg::*;

    localparam int unsigned COL_W     = $clog2(LINE_W);
    localparam int unsigned IDX_W     = $clog2(NUM_BUFS);
    localparam int unsigned FILL_BITS = $clog2(NUM_BUFS * LINE_W + 1);
    localparam logic [FILL_BITS-1:0] FILL_READY = FILL_BITS'(3 * LINE_W);

    lbc_state_t           state;
    lbc_state_t           stateNext;
    logic [COL_W-1:0]     wrCol;
    logic [COL_W-1:0]     rdCol;
    logic [IDX_W-1:0]     wrIdx;
    logic [FILL_BITS-1:0] fill;
    logic                 wrColWrap;
    logic                 rdColWrap;
    logic                 unusedWrIdxWrap;
    logic                 unusedRdTopWrap;
    logic                 readCycle;
    logic                 wrBlocked;
    logic                 wrAccept;

    assign readCycle    = (state == READ);
    assign kernel_valid = readCycle;

`ifdef LBC_OVF_GUARD_EN
    localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(NUM_BUFS * LINE_W);

    // A write with no concurrent read would push fill past the buffer capacity.
    assign wrBlocked = in_valid && (fill == FILL_FULL) && !readCycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if (wrBlocked) begin
            ovf_err <= 1'b1;
        end
    end
`else
    assign wrBlocked = 1'b0;
    assign ovf_err   = 1'b0;
`endif

    assign wrAccept  = in_valid && !wrBlocked;
    assign buf_wr_en = wrAccept ? (NUM_BUFS'(1) << wrIdx) : '0;

    mod_counter #(.MOD(LINE_W)) u_wr_col (
        .clk    (clk),
        .reset  (reset),
        .en     (wrAccept),
        .count  (wrCol),
        .wrap_c (wrColWrap)
    );

    mod_counter #(.MOD(NUM_BUFS)) u_wr_idx (
        .clk    (clk),
        .reset  (reset),
        .en     (wrColWrap),
        .count  (wrIdx),
        .wrap_c (unusedWrIdxWrap)
    );

    mod_counter #(.MOD(LINE_W)) u_rd_col (
        .clk    (clk),
        .reset  (reset),
        .en     (readCycle),
        .count  (rdCol),
        .wrap_c (rdColWrap)
    );

    mod_counter #(.MOD(NUM_BUFS)) u_rd_top (
        .clk    (clk),
        .reset  (reset),
        .en     (rdColWrap),
        .count  (rd_top_sel),
        .wrap_c (unusedRdTopWrap)
    );

    // Pixel occupancy: a write and a read column in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill <= '0;
        end else if (wrAccept && !readCycle) begin
            fill <= fill + FILL_BITS'(1);
        end else if (!wrAccept && readCycle) begin
            fill <= fill - FILL_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= stateNext;
            interrupt <= rdColWrap;
        end
    end

    // Next state and read-window enables.
    always_comb begin
        stateNext = state;
        buf_rd_en = '0;
        case (state)
            IDLE: begin
                if (fill >= FILL_READY) begin
                    stateNext = READ;
                end
            end
            READ: begin
                for (int i = 0; i < 3; i++) begin
                    buf_rd_en[rd_top_sel + IDX_W'(i)] = 1'b1;
                end
                if (rdColWrap) begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl: fill, refill handshake, concurrent
// write/read, reset mid-READ and the optional overflow guard.
module tb_line_buf_ctrl;

    import imgproc_pkg::*;

    localparam int LW = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] buf_wr_en;
    logic [3:0] buf_rd_en;
    logic [1:0] rd_top_sel;
    logic       kernel_valid;
    logic       interrupt;
    logic       ovf_err;

    int numChecks = 0;
    int numErrors = 0;
    int intCount  = 0;

    line_buf_ctrl #(.LINE_W(LW), .NUM_BUFS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .buf_wr_en    (buf_wr_en),
        .buf_rd_en    (buf_rd_en),
        .rd_top_sel   (rd_top_sel),
        .kernel_valid (kernel_valid),
        .interrupt    (interrupt),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (interrupt === 1'b1) intCount++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] expOneHot(input int idx);
        case (idx % 4)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [3:0] expRdEn(input int top);
        case (top % 4)
            0:       return 4'b0111;
            1:       return 4'b1110;
            2:       return 4'b1101;
            default: return 4'b1011;
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Write nPix pixels back to back, starting in line buffer startIdx.
    task automatic writeLines(input int nPix, input int startIdx);
        for (int p = 0; p < nPix; p++) begin
            in_valid = 1'b1;
            #1;
            checkVal("wr_en", buf_wr_en, expOneHot(startIdx + p / LW));
            checkVal("kv_during_fill", kernel_valid, 0);
            nextCycle();
        end
        in_valid = 1'b0;
    endtask

    // Starting on the cycle after the last write: one idle cycle, a full
    // read burst with window top expTop, then the interrupt cycle.
    task automatic checkBurst(input int expTop);
        #1;
        checkVal("kv_pre_read", kernel_valid, 0);
        checkVal("fill_ready", dut.fill, 3 * LW);
        nextCycle();
        for (int c = 0; c < LW; c++) begin
            #1;
            checkVal("kv_read", kernel_valid, 1);
            checkVal("rd_en", buf_rd_en, expRdEn(expTop));
            checkVal("top_read", rd_top_sel, expTop);
            checkVal("int_in_read", interrupt, 0);
            checkVal("ovf_read", ovf_err, 0);
            nextCycle();
        end
        #1;
        checkVal("int_pulse", interrupt, 1);
        checkVal("kv_int", kernel_valid, 0);
        checkVal("rd_en_int", buf_rd_en, 0);
        checkVal("top_adv", rd_top_sel, (expTop + 1) % 4);
        checkVal("fill_after", dut.fill, 2 * LW);
        nextCycle();
        #1;
        checkVal("int_drop", interrupt, 0);
        checkVal("kv_idle", kernel_valid, 0);
    endtask

    initial begin
        // Reset state, with in_valid both high and low.
        reset    = 1'b1;
        in_valid = 1'b1;
        nextCycle();
        nextCycle();
        #1;
        checkVal("rst_wr_en", buf_wr_en, 4'b0001);
        checkVal("rst_kv", kernel_valid, 0);
        checkVal("rst_rd_en", buf_rd_en, 0);
        checkVal("rst_top", rd_top_sel, 0);
        checkVal("rst_int", interrupt, 0);
        checkVal("rst_ovf", ovf_err, 0);
        checkVal("rst_fill", dut.fill, 0);
        in_valid = 1'b0;
        #1;
        checkVal("rst_wr_en_idle", buf_wr_en, 0);
        reset = 1'b0;

        // Basic fill of three lines, then the first read burst.
        writeLines(3 * LW, 0);
        checkBurst(0);

        // Refill one line after each interrupt, eight bursts in total.
        for (int i = 1; i < 8; i++) begin
            writeLines(LW, (i + 2) % 4);
            checkBurst(i % 4);
        end
        checkVal("int_count_8", intCount, 8);

        // Continuous streaming across two bursts; next write buffer is 2.
        for (int c = 0; c <= 1538; c++) begin
            automatic int  expFill = (c <= 512) ? 1024 + c : (c <= 1025) ? 1537 : 1538;
            automatic int  expTop  = (c < 1025) ? 0 : (c < 1538) ? 1 : 2;
            automatic bit  expKv   = (c >= 513 && c <= 1024) || (c >= 1026 && c <= 1537);
            automatic bit  expInt  = (c == 1025) || (c == 1538);
            in_valid = 1'b1;
            #1;
            checkVal("stream_wr_en", buf_wr_en, expOneHot(2 + c / LW));
            checkVal("stream_fill", dut.fill, expFill);
            checkVal("stream_kv", kernel_valid, expKv);
            checkVal("stream_int", interrupt, expInt);
            checkVal("stream_top", rd_top_sel, expTop);
            checkVal("stream_rd_en", buf_rd_en, expKv ? expRdEn(expTop) : 4'b0000);
            nextCycle();
        end
        in_valid = 1'b0;
        checkVal("int_count_10", intCount, 10);

        // Reset while the third streamed burst is at column 200.
        for (int k = 0; k < 200; k++) begin
            #1;
            nextCycle();
        end
        #1;
        checkVal("mid_kv", kernel_valid, 1);
        checkVal("mid_rdcol", dut.rdCol, 200);
        checkVal("mid_top", rd_top_sel, 2);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        #1;
        checkVal("mrst_kv", kernel_valid, 0);
        checkVal("mrst_rd_en", buf_rd_en, 0);
        checkVal("mrst_fill", dut.fill, 0);
        checkVal("mrst_int", interrupt, 0);
        checkVal("mrst_top", rd_top_sel, 0);
        checkVal("mrst_rdcol", dut.rdCol, 0);
        for (int k = 0; k < 600; k++) begin
            nextCycle();
        end
        checkVal("no_int_after_rst", intCount, 10);
        in_valid = 1'b1;
        #1;
        checkVal("mrst_wr_en", buf_wr_en, 4'b0001);
        in_valid = 1'b0;
        #1;

`ifdef LBC_OVF_GUARD_EN
        // Hold the FSM idle, fill every buffer, then attempt one more write.
        force dut.state = IDLE;
        writeLines(4 * LW, 0);
        #1;
        checkVal("ovf_full", dut.fill, 4 * LW);
        checkVal("ovf_pre", ovf_err, 0);
        in_valid = 1'b1;
        #1;
        checkVal("ovf_wr_en", buf_wr_en, 0);
        nextCycle();
        in_valid = 1'b0;
        #1;
        checkVal("ovf_set", ovf_err, 1);
        checkVal("ovf_fill_hold", dut.fill, 4 * LW);
        checkVal("ovf_wrcol_hold", dut.wrCol, 0);
        nextCycle();
        nextCycle();
        #1;
        checkVal("ovf_sticky", ovf_err, 1);
        release dut.state;
`else
        checkVal("ovf_tied", ovf_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 The module SHALL have parameter LINE_W, default 512, meaning pixels per image line, which is also the line-buffer depth.
REQ-002 The module SHALL have parameter NUM_BUFS, default 4, meaning the number of line buffers; the value 4 is fixed and no other value is supported.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a pixel is presented to the line buffers this cycle.
REQ-006 The module SHALL have port buf_wr_en, output, 4 bits: one-hot write enable per line buffer.
REQ-007 The module SHALL have port buf_rd_en, output, 4 bits: read enable per line buffer, three bits set while a read is active.
REQ-008 The module SHALL have port rd_top_sel, output, 2 bits: index of the top line of the current 3-line window, used for the window mux.
REQ-009 The module SHALL have port kernel_valid, output, 1 bit: a 3x3 window column is being read this cycle.
REQ-010 The module SHALL have port interrupt, output, 1 bit: one-cycle pulse meaning one line buffer has been freed and the host may send one more line.
REQ-011 The module SHALL have port ovf_err, output, 1 bit: sticky flag for a write attempted while all buffers are full.

Function
REQ-012 buf_wr_en SHALL equal onehot(wr_idx) when in_valid is high, else 0; this path is combinational with no added latency.
REQ-013 Write column counter wr_col SHALL increment on each accepted write; at LINE_W-1 it SHALL wrap to 0 and wr_idx SHALL advance by 1 mod 4.
REQ-014 fill (0..4*LINE_W, 12 bits at the default) SHALL count +1 per accepted write and -1 per read cycle; a simultaneous write and read SHALL leave fill unchanged.
REQ-015 The FSM SHALL have two states, IDLE and READ.
REQ-016 The FSM SHALL move IDLE->READ at the edge where registered fill >= 3*LINE_W.
REQ-017 The FSM SHALL stay in READ for exactly LINE_W cycles, counted by rd_col from 0 to LINE_W-1.
REQ-018 At the edge ending the read cycle with rd_col=LINE_W-1, the FSM SHALL go to IDLE, rd_col SHALL become 0, and rd_top_sel SHALL advance by 1 mod 4.
REQ-019 interrupt SHALL be registered and high for exactly the one cycle following the last READ cycle.
REQ-020 The FSM SHALL spend at least one IDLE cycle (the interrupt cycle) between consecutive READ bursts.
REQ-021 In READ, buf_rd_en SHALL have bits rd_top_sel, rd_top_sel+1 and rd_top_sel+2 (all mod 4) set; in IDLE it SHALL be 0.
REQ-022 kernel_valid SHALL be high exactly when state is READ.
REQ-023 Writes SHALL be accepted in both FSM states; a line being written SHALL never be one of the three lines being read. This is guaranteed by the fill bound of REQ-014/REQ-016 together with REQ-025.
REQ-024 Wrap-around: wr_idx and rd_top_sel SHALL wrap 3->0 with no gap cycle.

Reset
REQ-025 While reset is high at a clock edge, all of the following SHALL be cleared, including when reset is asserted mid-READ, and any pending interrupt SHALL be dropped:
- state=IDLE
- wr_col=0, wr_idx=0
- rd_col=0, rd_top_sel=0
- fill=0
- interrupt=0
- ovf_err=0
REQ-026 The reset values of buf_rd_en and kernel_valid SHALL be 0. buf_wr_en SHALL follow REQ-012, so it equals onehot(0) gated by in_valid.

Configuration
REQ-027 With macro LBC_OVF_GUARD_EN defined:
- a write with in_valid=1, fill=4*LINE_W and no read cycle SHALL be dropped: buf_wr_en=0, and counters and fill unchanged;
- ovf_err SHALL set and hold until reset.
REQ-028 With LBC_OVF_GUARD_EN undefined, writes SHALL never be gated, ovf_err SHALL be tied 0, and fill behaviour beyond full SHALL be unspecified.

Structure
REQ-029 The shared package imgproc_pkg SHALL hold LINE_W_DEFAULT=512, NUM_BUFS=4, the enum lbc_state_t {IDLE, READ}, and the fill width constant.
REQ-030 The single sub-module SHALL be mod_counter (parameterised modulus, enable, wrap pulse), instanced for wr_col, wr_idx, rd_col and rd_top_sel.

Verification
REQ-031 Test 1, basic fill:
- Stimulus: 1536 consecutive in_valid after reset.
- Required: buf_wr_en walks 0001 for 512 cycles, then 0010, then 0100; kernel_valid rises one cycle after fill=1536; buf_rd_en=0111 for 512 cycles; then interrupt for 1 cycle, and rd_top_sel=1.
REQ-032 Test 2, refill/interrupt handshake:
- Stimulus: after each interrupt, send 512 pixels; run to 8 interrupts.
- Required: buf_rd_en sequence 0111, 1110, 1101, 1011, 0111...; interrupt count equals the number of READ bursts.
REQ-033 Test 3, concurrent write and read:
- Stimulus: stream continuously with in_valid=1 during READ.
- Required: fill is constant during overlap cycles; wr_idx advances 3->0 without a gap.
REQ-034 Test 4, reset mid-READ:
- Stimulus: assert reset at rd_col=200.
- Required: next cycle kernel_valid=0, buf_rd_en=0, fill=0, and no interrupt pulse.
REQ-035 Test 5, overflow (LBC_OVF_GUARD_EN defined):
- Stimulus: fill to 2048, hold the FSM in IDLE by forcing, write 1 more.
- Required: buf_wr_en=0, ovf_err=1 and sticky; without the macro, ovf_err stays 0.
